// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: FSM states and the fetch
// next-PC select values.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic PC_SELECT_INC    = 1'b0;
  localparam logic PC_SELECT_TARGET = 1'b1;

endpackage

// File: rtl/fetch_controller.sv
// Sequences fetch PC against a single-outstanding instruction memory and hands
// instructions to decode over valid/ready; fetch is steered only via PC select.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ack,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  input  logic                    decode_ready,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_PC
);

  fetch_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDRESS_BITS-1:0] inst_PC_q, inst_PC_d;
  logic                    inst_valid_q, inst_valid_d;
  logic                    pend_redirect_q, pend_redirect_d;
  logic [ADDRESS_BITS-1:0] pend_PC_q, pend_PC_d;

  logic                    redirect_any;
  logic [ADDRESS_BITS-1:0] redirect_target;

  // A redirect arriving this cycle takes priority over one parked earlier.
  assign redirect_any    = redirect_valid | pend_redirect_q;
  assign redirect_target = redirect_valid ? redirect_PC : pend_PC_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      inst_q          <= '0;
      inst_PC_q       <= '0;
      inst_valid_q    <= 1'b0;
      pend_redirect_q <= 1'b0;
      pend_PC_q       <= '0;
    end else begin
      state_q         <= state_d;
      inst_q          <= inst_d;
      inst_PC_q       <= inst_PC_d;
      inst_valid_q    <= inst_valid_d;
      pend_redirect_q <= pend_redirect_d;
      pend_PC_q       <= pend_PC_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    inst_d          = inst_q;
    inst_PC_d       = inst_PC_q;
    inst_valid_d    = inst_valid_q;
    pend_redirect_d = pend_redirect_q;
    pend_PC_d       = pend_PC_q;
    next_PC_select  = PC_SELECT_TARGET;
    target_PC       = PC;
    imem_req        = 1'b0;
    imem_addr       = PC;

    case (state_q)
      IDLE: begin
        if (redirect_any) begin
          target_PC       = redirect_target;
          pend_redirect_d = 1'b0;
        end
        state_d = REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect_any) begin
            // Returned data belongs to the squashed path; drop it.
            target_PC       = redirect_target;
            pend_redirect_d = 1'b0;
            state_d         = IDLE;
          end else begin
            inst_d         = imem_rdata;
            inst_PC_d      = PC;
            inst_valid_d   = 1'b1;
            next_PC_select = PC_SELECT_INC;
            state_d        = HOLD;
          end
        end else if (redirect_valid) begin
          pend_redirect_d = 1'b1;
          pend_PC_d       = redirect_PC;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          inst_valid_d    = 1'b0;
          target_PC       = redirect_target;
          pend_redirect_d = 1'b0;
          state_d         = IDLE;
        end else if (inst_valid_q && decode_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_PC    = inst_PC_q;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the fetch PC register against a single-outstanding-request instruction memory and delivers instructions to decode through a valid/ready handshake.
- Applies redirects (branch/jump targets from execute) and stalls.
- Drives the fetch unit only through its existing next_PC_select/target_PC inputs. Hold is `next_PC_select=1`, `target_PC=PC`, so fetch needs no enable port.

Parameters:
- ADDRESS_BITS, 16, width of PC and memory address
- DATA_WIDTH, 32, instruction width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all controller state
- PC  in  ADDRESS_BITS  current PC from fetch
- next_PC_select  out  1  to fetch: 0 = PC+4, 1 = load target_PC
- target_PC  out  ADDRESS_BITS  to fetch: load value when next_PC_select=1
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDRESS_BITS  request address
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete
- imem_rdata  in  DATA_WIDTH  instruction data
- inst_valid  out  1  instruction held for decode
- inst  out  DATA_WIDTH  held instruction
- inst_PC  out  ADDRESS_BITS  address of held instruction
- decode_ready  in  1  decode accepts instruction
- redirect_valid  in  1  one-cycle redirect pulse (taken branch/jump)
- redirect_PC  in  ADDRESS_BITS  redirect target

Behaviour:
- States: IDLE, REQ, HOLD. Registers: state, inst, inst_PC, inst_valid, pend_redirect, pend_PC.
- Reset (sync, high): state=IDLE; inst_valid=0; inst=0; inst_PC=0; pend_redirect=0; pend_PC=0. Reset dominates all other inputs in the same cycle. Fetch is reset by the same signal, so PC=0 after reset.
- Default drive: next_PC_select=1, target_PC=PC (hold). "Advance" means next_PC_select=0 for one cycle. "Redirect-load" means next_PC_select=1 and target_PC = redirect_PC if redirect_valid, else pend_PC; it clears pend_redirect.
- IDLE: one cycle.
  - If redirect_valid or pend_redirect, redirect-load.
  - Go to REQ.
- REQ:
  - imem_req=1 and imem_addr=PC, stable until ack. PC is held.
  - redirect_valid without ack: latch pend_redirect=1, pend_PC=redirect_PC. The latest redirect wins.
  - ack with no redirect pending or arriving: inst<=imem_rdata, inst_PC<=PC, inst_valid<=1, advance, go to HOLD.
  - ack with redirect pending or arriving: discard rdata, inst_valid stays 0, redirect-load, go to IDLE.
  - imem_req is 0 in IDLE and HOLD, and in the cycle after an ack.
- HOLD:
  - inst_valid=1, outputs stable, PC held.
  - accept = inst_valid & decode_ready & ~redirect_valid.
  - On accept: inst_valid<=0, go to REQ.
  - redirect_valid: drop the held instruction (inst_valid<=0), redirect-load, go to IDLE.
  - Decode must gate its own capture with ~redirect_valid; this is the shared flush rule.
- Latency: ack to inst_valid is 1 cycle. Accept to next imem_req is 1 cycle. Redirect to first request at the new PC is 2 cycles.
- Address arithmetic is done by fetch (PC+4, wrapping modulo 2^ADDRESS_BITS). At PC=FFFC, advance gives 0000.
- Redirect in the same cycle as reset: ignored.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, REQ=2'd1, HOLD=2'd2)
  - PC_SELECT_INC=1'b0 and PC_SELECT_TARGET=1'b1
- No sub-module; a single FSM module instantiated beside fetch in the top-level CPU.

Test Plan:
- Reset for 2 cycles, release; ack at 2nd REQ cycle with rdata=00500093 -> imem_addr=0000, then inst_valid=1, inst=00500093, inst_PC=0000; after accept, PC=0004 and imem_addr=0004.
- decode_ready=0 for 3 cycles in HOLD -> inst/inst_PC stable, PC stays 0004, imem_req=0; decode_ready=1 -> inst_valid drops next cycle.
- redirect_valid with redirect_PC=000C while in HOLD -> held instruction dropped (no accept), PC=000C, next imem_addr=000C.
- redirect_PC=0020 during REQ (ack 2 cycles later, rdata=DEADBEEF) -> inst_valid never rises for DEADBEEF, PC=0020, next request at 0020.
- Two redirects during one REQ (0040, then 0080) -> next request at 0080.
- reset asserted mid-REQ and in HOLD -> next cycle state IDLE, inst_valid=0, imem_req=0, PC=0000, pending redirect cleared.
